// File: rtl/snd_dma_addr.sv
// snd_dma_addr: STE sound DMA frame start/end registers and word address counter.
// With SHADOW=1, CPU start/end writes are staged and become active at each frame (re)start.
module snd_dma_addr #(
    parameter bit SHADOW = 1'b1
) (
    input  logic        clk32,
    input  logic        porb,
    input  logic        reg_we,
    input  logic [4:0]  reg_addr,
    input  logic [7:0]  reg_din,
    output logic [7:0]  reg_dout,
    input  logic        inc_en,
    output logic [21:1] snd,
    output logic [21:1] sft,
    output logic        sndon,
    output logic        sfrep,
    output logic        frame_start,
    output logic        frame_done
);
    logic [21:1] start_q, end_q, act_q, start_w, end_w;
    logic wc, go, hit, rel;

    function automatic logic [21:1] put(input logic [21:1] v, input logic [4:0] a,
                                        input logic [4:0] base, input logic [7:0] d);
        put = v;
        if (a == base) put[21:16] = d[5:0];
        if (a == base + 5'd1) put[15:8] = d;
        if (a == base + 5'd2) put[7:1] = d[7:1];
    endfunction

    // start_w/end_w already hold a same-cycle CPU byte, so a reload picks it up
    always_comb begin
        start_w = reg_we ? put(start_q, reg_addr, 5'd1, reg_din) : start_q;
        end_w   = reg_we ? put(end_q, reg_addr, 5'd7, reg_din) : end_q;
        wc      = reg_we && reg_addr == 5'd0;
        go      = wc && reg_din[0] && !sndon;
        hit     = inc_en && sndon && snd == sft;
        rel     = go || (hit && sfrep);
    end

    assign sft = act_q;

    always_ff @(posedge clk32 or negedge porb)
        if (!porb) begin
            start_q     <= '0;
            end_q       <= '0;
            act_q       <= '0;
            snd         <= '0;
            sndon       <= 1'b0;
            sfrep       <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            start_q     <= start_w;
            end_q       <= end_w;
            act_q       <= (rel || !SHADOW) ? end_w : act_q;
            snd         <= rel ? start_w : (inc_en && sndon && !hit) ? snd + 21'd1 : snd;
            sndon       <= wc ? reg_din[0] : sndon && !(hit && !sfrep);
            sfrep       <= wc ? reg_din[1] : sfrep;
            frame_start <= rel;
            frame_done  <= hit;
        end

    always_comb begin
        case (reg_addr)
            5'd0:    reg_dout = {6'b0, sfrep, sndon};
            5'd1:    reg_dout = {2'b0, start_q[21:16]};
            5'd2:    reg_dout = start_q[15:8];
            5'd3:    reg_dout = {start_q[7:1], 1'b0};
            5'd4:    reg_dout = {2'b0, snd[21:16]};
            5'd5:    reg_dout = snd[15:8];
            5'd6:    reg_dout = {snd[7:1], 1'b0};
            5'd7:    reg_dout = {2'b0, end_q[21:16]};
            5'd8:    reg_dout = end_q[15:8];
            5'd9:    reg_dout = {end_q[7:1], 1'b0};
            default: reg_dout = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_snd_dma_addr.sv
// tb_snd_dma_addr: shadowed and direct instances driven in lockstep, checked each cycle
// against a byte-address arithmetic model, plus literal frame scenarios.
module tb_snd_dma_addr;
    logic clk32 = 0, porb = 1, reg_we = 0, inc_en = 0;
    logic [4:0] reg_addr = 0;
    logic [7:0] reg_din = 0;
    logic [7:0] dout1, dout0;
    logic [21:1] snd1, snd0, sft1, sft0;
    logic on1, on0, rep1, rep0, fs1, fs0, fd1, fd0;

    snd_dma_addr #(.SHADOW(1'b1)) d1 (
        .clk32(clk32), .porb(porb), .reg_we(reg_we), .reg_addr(reg_addr), .reg_din(reg_din),
        .reg_dout(dout1), .inc_en(inc_en), .snd(snd1), .sft(sft1), .sndon(on1), .sfrep(rep1),
        .frame_start(fs1), .frame_done(fd1));
    snd_dma_addr #(.SHADOW(1'b0)) d0 (
        .clk32(clk32), .porb(porb), .reg_we(reg_we), .reg_addr(reg_addr), .reg_din(reg_din),
        .reg_dout(dout0), .inc_en(inc_en), .snd(snd0), .sft(sft0), .sndon(on0), .sfrep(rep0),
        .frame_start(fs0), .frame_done(fd0));

    always #5 clk32 = ~clk32;

    int m_on[2], m_rep[2], m_st[2], m_es[2], m_ea[2], m_snd[2], m_fs[2], m_fd[2];
    int n_chk = 0, n_pass = 0;

    // model keeps word addresses; byte lanes are applied on the byte address
    function automatic int wbyte(int w, int off, int d);
        int b;
        b = w * 2;
        if (off == 0) b = (b & 'h00FFFF) | ((d & 'h3F) << 16);
        else if (off == 1) b = (b & 'h3F00FF) | ((d & 'hFF) << 8);
        else b = (b & 'h3FFF00) | (d & 'hFE);
        return b / 2;
    endfunction

    function automatic int rbyte(int w, int off);
        int b;
        b = w * 2;
        return off == 0 ? b >> 16 : off == 1 ? (b >> 8) & 'hFF : b & 'hFF;
    endfunction

    task automatic step(int m);
        int st, es, nsnd, non, nrep, nea, fsv, fdv, a, d;
        st = m_st[m]; es = m_es[m]; nsnd = m_snd[m]; non = m_on[m]; nrep = m_rep[m];
        nea = m_ea[m]; fsv = 0; fdv = 0; a = int'(reg_addr); d = int'(reg_din);
        if (reg_we && a >= 1 && a <= 3) st = wbyte(st, a - 1, d);
        if (reg_we && a >= 7 && a <= 9) es = wbyte(es, a - 7, d);
        if (m == 0) nea = es;
        if (reg_we && a == 0 && d % 2 == 1 && m_on[m] == 0) begin
            fsv = 1; nsnd = st; nea = es;
        end else if (inc_en && m_on[m] == 1) begin
            if (m_snd[m] == m_ea[m]) begin
                fdv = 1;
                if (m_rep[m] == 1) begin fsv = 1; nsnd = st; nea = es; end
                else non = 0;
            end else nsnd = (m_snd[m] + 1) % (1 << 21);
        end
        if (reg_we && a == 0) begin non = d % 2; nrep = (d / 2) % 2; end
        m_st[m] = st; m_es[m] = es; m_snd[m] = nsnd; m_on[m] = non; m_rep[m] = nrep;
        m_ea[m] = nea; m_fs[m] = fsv; m_fd[m] = fdv;
    endtask

    always @(posedge clk32 or negedge porb)
        if (!porb) begin
            for (int m = 0; m < 2; m++) begin
                m_on[m] = 0; m_rep[m] = 0; m_st[m] = 0; m_es[m] = 0;
                m_ea[m] = 0; m_snd[m] = 0; m_fs[m] = 0; m_fd[m] = 0;
            end
        end else begin
            step(1);
            step(0);
        end

    function automatic int exp_dout(int m);
        int a;
        a = int'(reg_addr);
        if (a == 0) return m_rep[m] * 2 + m_on[m];
        if (a >= 1 && a <= 3) return rbyte(m_st[m], a - 1);
        if (a >= 4 && a <= 6) return rbyte(m_snd[m], a - 4);
        if (a >= 7 && a <= 9) return rbyte(m_es[m], a - 7);
        return 0;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk32) begin
        chk("d1.snd", int'(snd1), m_snd[1]);
        chk("d1.sft", int'(sft1), m_ea[1]);
        chk("d1.sndon", int'(on1), m_on[1]);
        chk("d1.sfrep", int'(rep1), m_rep[1]);
        chk("d1.frame_start", int'(fs1), m_fs[1]);
        chk("d1.frame_done", int'(fd1), m_fd[1]);
        chk("d1.reg_dout", int'(dout1), exp_dout(1));
        chk("d0.snd", int'(snd0), m_snd[0]);
        chk("d0.sft", int'(sft0), m_ea[0]);
        chk("d0.sndon", int'(on0), m_on[0]);
        chk("d0.sfrep", int'(rep0), m_rep[0]);
        chk("d0.frame_start", int'(fs0), m_fs[0]);
        chk("d0.frame_done", int'(fd0), m_fd[0]);
        chk("d0.reg_dout", int'(dout0), exp_dout(0));
    end

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    task automatic wr(int a, int d);
        reg_we = 1; reg_addr = a[4:0]; reg_din = d[7:0];
        tick();
        reg_we = 0; reg_addr = 0;
    endtask

    task automatic inc();
        inc_en = 1;
        tick();
        inc_en = 0;
    endtask

    task automatic setse(int s, int e);
        wr(1, s >> 16); wr(2, s >> 8); wr(3, s);
        wr(7, e >> 16); wr(8, e >> 8); wr(9, e);
    endtask

    task automatic rd(int a, int exp, string nm);
        reg_addr = a[4:0];
        #1;
        chk(nm, int'(dout1), exp);
    endtask

    initial begin
        #1 porb = 0;
        repeat (3) tick();
        chk("rst snd", int'(snd1), 0);
        chk("rst sndon", int'(on1), 0);
        porb = 1;
        setse('h012340, 'h012346);
        rd(1, 'h01, "rb start hi"); rd(2, 'h23, "rb start mid"); rd(3, 'h40, "rb start lo");
        rd(7, 'h01, "rb end hi"); rd(8, 'h23, "rb end mid"); rd(9, 'h46, "rb end lo");
        rd(4, 'h00, "rb cnt hi");
        reg_addr = 0;
        tick();
        wr(0, 1);
        chk("single start snd", int'(snd1), 'h91A0);
        chk("single frame_start", int'(fs1), 1);
        for (int i = 1; i <= 3; i++) begin
            inc();
            chk("single snd", int'(snd1), 'h91A0 + i);
        end
        inc();
        chk("single frame_done", int'(fd1), 1);
        chk("single sndon off", int'(on1), 0);
        chk("single snd hold", int'(snd1), 'h91A3);
        tick();
        wr(0, 3);
        chk("rep start snd", int'(snd1), 'h91A0);
        repeat (3) inc();
        inc();
        chk("rep frame_done", int'(fd1), 1);
        chk("rep frame_start", int'(fs1), 1);
        chk("rep snd reload", int'(snd1), 'h91A0);
        chk("rep sndon", int'(on1), 1);
        wr(9, 'h50);
        chk("shadow sft held", int'(sft1), 'h91A3);
        chk("direct sft new", int'(sft0), 'h91A8);
        repeat (3) inc();
        inc();
        chk("shadow sft reload", int'(sft1), 'h91A8);
        chk("shadow frame_start", int'(fs1), 1);
        wr(0, 0);
        setse('h012340, 'h012346);
        wr(0, 3);
        repeat (3) inc();
        reg_we = 1; reg_addr = 0; reg_din = 0; inc_en = 1;
        tick();
        reg_we = 0; inc_en = 0;
        chk("coll sndon", int'(on1), 0);
        chk("coll snd reload", int'(snd1), 'h91A0);
        chk("coll frame_done", int'(fd1), 1);
        chk("coll sfrep", int'(rep1), 0);
        setse('h3FFFFC, 'h000002);
        wr(0, 1);
        chk("wrap snd0", int'(snd1), 'h1FFFFE);
        inc(); chk("wrap snd1", int'(snd1), 'h1FFFFF);
        inc(); chk("wrap snd2", int'(snd1), 'h000000);
        inc(); chk("wrap snd3", int'(snd1), 'h000001);
        chk("wrap no done yet", int'(fd1), 0);
        inc(); chk("wrap frame_done", int'(fd1), 1);
        wr(0, 3);
        inc();
        #2 porb = 0;
        #1;
        chk("async rst snd", int'(snd1), 0);
        chk("async rst sft", int'(sft1), 0);
        chk("async rst sndon", int'(on1), 0);
        tick();
        porb = 1;
        repeat (3) tick();
        chk("post rst frame_start", int'(fs1), 0);
        setse('h000200, 'h000240);
        for (int i = 0; i < 3000; i++) begin
            int a;
            a = $urandom_range(0, 15);
            reg_we = ($urandom_range(0, 3) == 0);
            reg_addr = a[4:0];
            reg_din = 8'($urandom);
            if ((a == 1 || a == 2 || a == 7 || a == 8) && $urandom_range(0, 7) != 0) reg_din = 0;
            inc_en = 1'($urandom_range(0, 1));
            porb = ($urandom_range(0, 499) != 0);
            tick();
        end
        reg_we = 0; inc_en = 0; porb = 1;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/snd_dma_addr.md
Name: snd_dma_addr

Overview:
- Sound DMA address generator for the STE-compatible MCU.
- Holds the CPU-visible sound control, frame-start and frame-end registers, and runs the word address counter.
- Drives snd[21:1], sft[21:1], sndon and sfrep into mcucontrol; mcucontrol uses them for end compare, stoff, sframe and sint.
- Everything runs on clk32, using single-cycle enables in the same style as the rest of the MCU.

Parameters:
- SHADOW, default 1: 1 = CPU writes to start/end go to shadow registers and are copied to the active registers at each frame (re)start; 0 = writes go directly to the active registers.

Ports:
- clk32  in  1  master clock; all state changes on its rising edge.
- porb  in  1  asynchronous active-low reset.
- reg_we  in  1  one-clk32 write strobe.
- reg_addr  in  5  word offset within $FF8900: 0 ctrl, 1/2/3 start hi/mid/lo, 4/5/6 counter hi/mid/lo, 7/8/9 end hi/mid/lo.
- reg_din  in  8  write data (odd byte lane).
- reg_dout  out  8  combinational readback for reg_addr.
- inc_en  in  1  one-clk32 pulse per sound word fetched (sndclk edge enable).
- snd  out  21  current sound DMA word address [21:1].
- sft  out  21  active frame end address [21:1].
- sndon  out  1  DMA enable (ctrl bit0).
- sfrep  out  1  repeat mode (ctrl bit1).
- frame_start  out  1  one-clk32 pulse when a frame is (re)started.
- frame_done  out  1  one-clk32 pulse when the end address is consumed.

Behaviour:
- Reset (porb=0), asynchronous: ctrl, start, end, shadow and snd all 0. All outputs 0, including the pulses.
- Register widths:
  - hi byte maps to bits [21:16]; reg_din[7:6] are ignored and read as 0.
  - mid byte maps to [15:8].
  - lo byte maps to [7:1]; reg_din[0] is ignored and reads as 0.
- Readback:
  - ctrl reads {6'b0, sfrep, sndon}.
  - start/end read the shadow value when SHADOW=1, otherwise the active value.
  - counter bytes read live snd.
  - Unused offsets read 8'h00.
- Counter offsets 4–6 are read-only; writes to them are ignored.
- Start from idle: a ctrl write with bit0=1 while sndon=0:
  - active start/end <= shadow (when SHADOW=1);
  - snd <= start value (the new one);
  - frame_start pulses in the same cycle as the register update;
  - takes effect on the next edge.
- Stop: a ctrl write with bit0=0 clears sndon; snd holds its value. A ctrl write with bit0=1 while sndon=1 only updates sfrep; there is no restart.
- inc_en with sndon=1:
  - snd != sft: snd <= snd+1, wrapping 21'h1FFFFF to 0.
  - snd == sft: frame_done pulses, then:
    - sfrep=1: reload active start/end from shadow, snd <= new start, frame_start pulses.
    - sfrep=0: sndon <= 0, snd holds.
- inc_en with sndon=0 is ignored.
- Simultaneous events:
  - A ctrl write and an end-of-frame stop in the same cycle: the CPU write wins for sndon/sfrep; the counter action still follows the rules above.
  - A shadow write and a reload in the same cycle: the reload uses the newly written byte.
  - In direct mode (SHADOW=0), a write to the active register and an inc_en compare in the same cycle: the compare uses the pre-write value.
- Start == end: the frame is one word long; frame_done fires on the first inc_en.
- End below start: the counter runs up, wraps through 21'h1FFFFF, and stops or reloads only on exact equality.
- Reset mid-frame aborts immediately. No pulses are emitted after porb rises until a new start.

Test Plan:
- Reset/readback: assert porb=0 mid-operation → all outputs 0. Then write start=$012340, end=$012346 and read offsets 1–3, 7–9 → $01,$23,$40 / $01,$23,$46; offset 4 reads 0.
- Single frame: start=$012340, end=$012346, ctrl=1, then 4 inc_en → snd word addresses $91A0..$91A3. frame_done occurs on the 4th pulse, sndon=0 after it, snd holds $91A3.
- Repeat: same setup with ctrl=3 → on the 4th inc_en, frame_done and frame_start pulse together, snd=$91A0, sndon stays 1.
- Shadow: during a repeat frame write end=$012350 → sft unchanged until the next reload, then sft=$91A8. With SHADOW=0, sft changes the cycle after the write.
- Collision: ctrl write of 0 in the same cycle as the final inc_en with sfrep=1 → sndon=0; snd still reloads to start; frame_done=1.
- Wrap: start=$3FFFFC, end=$000002, ctrl=1 → snd goes $1FFFFE, $1FFFFF, $000000, $000001; frame_done occurs on the 4th inc_en.
